// File: rtl/eq_stream_checker.sv
// rtl/eq_stream_checker.sv - handshaked equality checker with match/mismatch statistics
module eq_stream_checker #(
    parameter int WIDTH  = 3,
    parameter int CNT_W  = 8,
    parameter int STREAK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             ne,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             streak_hit,
    output logic             any_mismatch
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] STREAK_PRE = CNT_W'(STREAK - 1);

    logic [CNT_W-1:0] run_cnt;
    logic             accept;
    logic             pair_eq;

    // One-entry pipeline: a new pair may enter whenever the held result leaves.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign pair_eq  = (a == b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            eq        <= 1'b0;
            ne        <= 1'b0;
            y         <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            eq        <= pair_eq;
            ne        <= !pair_eq;
            y         <= pair_eq ? a : b;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Statistics; clear takes priority over a same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            run_cnt      <= '0;
            streak_hit   <= 1'b0;
            any_mismatch <= 1'b0;
        end else if (clear) begin
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            run_cnt      <= '0;
            streak_hit   <= 1'b0;
            any_mismatch <= 1'b0;
        end else begin
            streak_hit <= 1'b0;
            if (accept) begin
                if (pair_eq) begin
                    if (match_cnt != CNT_MAX) match_cnt <= match_cnt + 1'b1;
                    if (run_cnt != CNT_MAX)   run_cnt   <= run_cnt + 1'b1;
                    if (run_cnt == STREAK_PRE) streak_hit <= 1'b1;
                end else begin
                    if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + 1'b1;
                    run_cnt      <= '0;
                    any_mismatch <= 1'b1;
                end
            end
        end
    end

endmodule
